decode_stage: RTL and testbench

- Registered, parametrised RV32/RV64 instruction decode stage between fetch and register-read.
- Accepts one 32-bit instruction plus PC per valid/ready handshake.
- Decodes opcode, instruction type, register fields, funct fields, legality and the XLEN-wide sign-extended immediate.
- Presents the result one cycle later, with an optional skid buffer so back-pressure does not create a combinational ready path.

---
 rtl/rv_pkg.sv | 68 ++++++
 rtl/decode_comb.sv | 89 ++++++++
 rtl/decode_stage.sv | 141 ++++++++++++++
 tb/tb_decode_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: major opcodes, one-hot instruction
// formats, instruction field positions and the decoded-field bundle.
package rv_pkg;

  // Major opcodes, inst[6:2]
  localparam logic [4:0] OPCODE_LOAD      = 5'h00;
  localparam logic [4:0] OPCODE_LOAD_FP   = 5'h01;
  localparam logic [4:0] OPCODE_CUSTOM_0  = 5'h02;
  localparam logic [4:0] OPCODE_MISC_MEM  = 5'h03;
  localparam logic [4:0] OPCODE_OP_IMM    = 5'h04;
  localparam logic [4:0] OPCODE_AUIPC     = 5'h05;
  localparam logic [4:0] OPCODE_OP_IMM_32 = 5'h06;
  localparam logic [4:0] OPCODE_STORE     = 5'h08;
  localparam logic [4:0] OPCODE_STORE_FP  = 5'h09;
  localparam logic [4:0] OPCODE_CUSTOM_1  = 5'h0A;
  localparam logic [4:0] OPCODE_AMO       = 5'h0B;
  localparam logic [4:0] OPCODE_OP        = 5'h0C;
  localparam logic [4:0] OPCODE_LUI       = 5'h0D;
  localparam logic [4:0] OPCODE_OP_32     = 5'h0E;
  localparam logic [4:0] OPCODE_MADD      = 5'h10;
  localparam logic [4:0] OPCODE_MSUB      = 5'h11;
  localparam logic [4:0] OPCODE_NMSUB     = 5'h12;
  localparam logic [4:0] OPCODE_NMADD     = 5'h13;
  localparam logic [4:0] OPCODE_OP_FP     = 5'h14;
  localparam logic [4:0] OPCODE_CUSTOM_2  = 5'h16;
  localparam logic [4:0] OPCODE_BRANCH    = 5'h18;
  localparam logic [4:0] OPCODE_JALR      = 5'h19;
  localparam logic [4:0] OPCODE_JAL       = 5'h1B;
  localparam logic [4:0] OPCODE_SYSTEM    = 5'h1C;
  localparam logic [4:0] OPCODE_CUSTOM_3  = 5'h1E;

  // One-hot instruction formats {J,U,B,S,I,R}; NONE marks an illegal instruction
  localparam logic [5:0] INST_TYPE_NONE = 6'b000000;
  localparam logic [5:0] INST_TYPE_R    = 6'b000001;
  localparam logic [5:0] INST_TYPE_I    = 6'b000010;
  localparam logic [5:0] INST_TYPE_S    = 6'b000100;
  localparam logic [5:0] INST_TYPE_B    = 6'b001000;
  localparam logic [5:0] INST_TYPE_U    = 6'b010000;
  localparam logic [5:0] INST_TYPE_J    = 6'b100000;

  // Field LSB positions inside the 32-bit instruction word
  localparam int OPCODE_LSB = 2;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  // Occupancy of the decode stage: nothing, output register only, output + skid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  // XLEN-independent part of a decoded instruction
  typedef struct packed {
    logic [4:0] opcode;
    logic [5:0] inst_type;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32/RV64 decoder: format, legality, gated register
// and function fields, and the XLEN-wide sign-extended immediate.
module decode_comb
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_F = 0
) (
  input  logic [31:0]     inst,
  output logic [5:0]      inst_type,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [4:0]  opcode;
  logic [5:0]  type_raw;
  logic        bad_len;
  logic [31:0] imm32;

  assign opcode = inst[OPCODE_LSB +: 5];

  // Map the major opcode to a format; unsupported opcodes stay NONE
  always_comb begin
    type_raw = INST_TYPE_NONE;
    case (opcode)
      OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM,
      OPCODE_JALR, OPCODE_SYSTEM:                  type_raw = INST_TYPE_I;
      OPCODE_OP_IMM_32: if (XLEN == 64)            type_raw = INST_TYPE_I;
      OPCODE_STORE:                                type_raw = INST_TYPE_S;
      OPCODE_BRANCH:                               type_raw = INST_TYPE_B;
      OPCODE_AUIPC, OPCODE_LUI:                    type_raw = INST_TYPE_U;
      OPCODE_JAL:                                  type_raw = INST_TYPE_J;
      OPCODE_OP, OPCODE_AMO:                       type_raw = INST_TYPE_R;
      OPCODE_OP_32: if (XLEN == 64)                type_raw = INST_TYPE_R;
      OPCODE_LOAD_FP: if (EN_F != 0)               type_raw = INST_TYPE_I;
      OPCODE_STORE_FP: if (EN_F != 0)              type_raw = INST_TYPE_S;
      OPCODE_MADD, OPCODE_MSUB, OPCODE_NMSUB,
      OPCODE_NMADD, OPCODE_OP_FP: if (EN_F != 0)   type_raw = INST_TYPE_R;
      default:                                     type_raw = INST_TYPE_NONE;
    endcase
  end

  // Compressed (low bits != 11) and >32-bit encodings (inst[4:2]==111) are never legal here
  assign bad_len   = (inst[1:0] != 2'b11) || (inst[4:2] == 3'b111);
  assign illegal   = bad_len || (type_raw == INST_TYPE_NONE);
  assign inst_type = illegal ? INST_TYPE_NONE : type_raw;

  // Pass each field only for the formats that actually carry it
  always_comb begin
    rd     = '0;
    rs1    = '0;
    rs2    = '0;
    funct3 = '0;
    funct7 = '0;
    if (|(inst_type & (INST_TYPE_R | INST_TYPE_I | INST_TYPE_U | INST_TYPE_J)))
      rd = inst[RD_LSB +: 5];
    if (|(inst_type & (INST_TYPE_R | INST_TYPE_I | INST_TYPE_S | INST_TYPE_B))) begin
      rs1    = inst[RS1_LSB +: 5];
      funct3 = inst[FUNCT3_LSB +: 3];
    end
    if (|(inst_type & (INST_TYPE_R | INST_TYPE_S | INST_TYPE_B)))
      rs2 = inst[RS2_LSB +: 5];
    if (inst_type == INST_TYPE_R)
      funct7 = inst[FUNCT7_LSB +: 7];
  end

  // Build the 32-bit immediate per format, then sign-extend from bit 31 to XLEN
  always_comb begin
    imm32 = '0;
    if (inst_type == INST_TYPE_I)
      imm32 = {{20{inst[31]}}, inst[31:20]};
    else if (inst_type == INST_TYPE_S)
      imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (inst_type == INST_TYPE_B)
      imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (inst_type == INST_TYPE_U)
      imm32 = {inst[31:12], 12'b0};
    else if (inst_type == INST_TYPE_J)
      imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and register-read.
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and payload is held stable while
// valid & !ready. Decode happens before the registers, so the output
// register and the optional skid register both hold decoded results.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1,
  parameter int EN_F = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_opcode,
  output logic [5:0]      out_inst_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  dec_fields_t     dec;
  logic [XLEN-1:0] dec_imm;
  dec_fields_t     out_q;
  dec_fields_t     skid_q;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_imm;
  // state is the stage occupancy and is the signal to watch when debugging
  stage_state_e    state;
  logic            in_ready_q;
  logic            in_fire;
  logic            out_fire;

  assign dec.opcode = in_inst[OPCODE_LSB +: 5];

  decode_comb #(
    .XLEN (XLEN),
    .EN_F (EN_F)
  ) u_decode_comb (
    .inst      (in_inst),
    .inst_type (dec.inst_type),
    .rd        (dec.rd),
    .rs1       (dec.rs1),
    .rs2       (dec.rs2),
    .funct3    (dec.funct3),
    .funct7    (dec.funct7),
    .imm       (dec_imm),
    .illegal   (dec.illegal)
  );

  // With a skid buffer ready comes from a register; without it ready follows
  // the output side. Reset and flush both block acceptance.
  assign in_ready = rst_n && !flush &&
                    ((SKID != 0) ? in_ready_q : (!out_valid || out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Occupancy FSM moving decoded instructions through output and skid registers in order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      out_pc     <= '0;
      out_imm    <= '0;
      skid_q     <= '0;
      skid_pc    <= '0;
      skid_imm   <= '0;
    end else if (flush) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_q     <= dec;
            out_pc    <= in_pc;
            out_imm   <= dec_imm;
            out_valid <= 1'b1;
            state     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            out_q   <= dec;
            out_pc  <= in_pc;
            out_imm <= dec_imm;
          end else if (in_fire) begin
            // Only reachable with the skid buffer: park the newcomer behind the output
            skid_q     <= dec;
            skid_pc    <= in_pc;
            skid_imm   <= dec_imm;
            in_ready_q <= 1'b0;
            state      <= ST_SKID;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            out_q      <= skid_q;
            out_pc     <= skid_pc;
            out_imm    <= skid_imm;
            in_ready_q <= 1'b1;
            state      <= ST_FULL;
          end
        end
        default: begin
          state      <= ST_EMPTY;
          out_valid  <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign out_opcode    = out_q.opcode;
  assign out_inst_type = out_q.inst_type;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instance a (XLEN=32, SKID=1, EN_F=0) and
// instance b (XLEN=64, SKID=0, EN_F=1) share clock and reset.
module tb_decode_stage;

  localparam logic [5:0] T_N = 6'b000000;
  localparam logic [5:0] T_R = 6'b000001;
  localparam logic [5:0] T_I = 6'b000010;
  localparam logic [5:0] T_S = 6'b000100;
  localparam logic [5:0] T_B = 6'b001000;
  localparam logic [5:0] T_U = 6'b010000;
  localparam logic [5:0] T_J = 6'b100000;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  opcode;
    logic [5:0]  itype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } rec_t;

  typedef struct {
    int          dut;
    logic [31:0] inst;
    rec_t        exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic        in_valid[2];
  logic [31:0] in_inst[2];
  logic [63:0] in_pc[2];
  logic        out_ready[2];
  logic        flush[2];
  logic        in_rdy[2];
  logic        ovld[2];
  rec_t        act[2];

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_pc, a_out_imm;
  logic [4:0]  a_out_opcode, a_out_rd, a_out_rs1, a_out_rs2;
  logic [5:0]  a_out_inst_type;
  logic [2:0]  a_out_funct3;
  logic [6:0]  a_out_funct7;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_pc, b_out_imm;
  logic [4:0]  b_out_opcode, b_out_rd, b_out_rs1, b_out_rs2;
  logic [5:0]  b_out_inst_type;
  logic [2:0]  b_out_funct3;
  logic [6:0]  b_out_funct7;

  decode_stage #(.XLEN(32), .SKID(1), .EN_F(0)) dut_a (
    .clk (clk), .rst_n (rst_n), .flush (flush[0]),
    .in_valid (in_valid[0]), .in_ready (a_in_ready),
    .in_inst (in_inst[0]), .in_pc (in_pc[0][31:0]),
    .out_valid (a_out_valid), .out_ready (out_ready[0]),
    .out_pc (a_out_pc), .out_opcode (a_out_opcode), .out_inst_type (a_out_inst_type),
    .out_rd (a_out_rd), .out_rs1 (a_out_rs1), .out_rs2 (a_out_rs2),
    .out_funct3 (a_out_funct3), .out_funct7 (a_out_funct7),
    .out_imm (a_out_imm), .out_illegal (a_out_illegal)
  );

  decode_stage #(.XLEN(64), .SKID(0), .EN_F(1)) dut_b (
    .clk (clk), .rst_n (rst_n), .flush (flush[1]),
    .in_valid (in_valid[1]), .in_ready (b_in_ready),
    .in_inst (in_inst[1]), .in_pc (in_pc[1]),
    .out_valid (b_out_valid), .out_ready (out_ready[1]),
    .out_pc (b_out_pc), .out_opcode (b_out_opcode), .out_inst_type (b_out_inst_type),
    .out_rd (b_out_rd), .out_rs1 (b_out_rs1), .out_rs2 (b_out_rs2),
    .out_funct3 (b_out_funct3), .out_funct7 (b_out_funct7),
    .out_imm (b_out_imm), .out_illegal (b_out_illegal)
  );

  always_comb begin
    in_rdy[0] = a_in_ready;
    in_rdy[1] = b_in_ready;
    ovld[0]   = a_out_valid;
    ovld[1]   = b_out_valid;
    act[0] = '{pc: {32'b0, a_out_pc}, opcode: a_out_opcode, itype: a_out_inst_type,
               rd: a_out_rd, rs1: a_out_rs1, rs2: a_out_rs2, f3: a_out_funct3,
               f7: a_out_funct7, imm: {32'b0, a_out_imm}, ill: a_out_illegal};
    act[1] = '{pc: b_out_pc, opcode: b_out_opcode, itype: b_out_inst_type,
               rd: b_out_rd, rs1: b_out_rs1, rs2: b_out_rs2, f3: b_out_funct3,
               f7: b_out_funct7, imm: b_out_imm, ill: b_out_illegal};
  end

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  rec_t exp_q0[$];
  rec_t exp_q1[$];

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void check_rec(input string name, input rec_t got, input rec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic rec_t mk(input logic [63:0] pc, input logic [4:0] opc, input logic [5:0] ty,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] imm, input logic ill);
    rec_t r;
    r = '{pc: pc, opcode: opc, itype: ty, rd: rd, rs1: rs1, rs2: rs2,
          f3: f3, f7: f7, imm: imm, ill: ill};
    return r;
  endfunction

  // Pop and compare whenever an output transfer is about to happen
  always @(negedge clk) begin
    if (rst_n && a_out_valid && out_ready[0] && !flush[0]) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_output: got pc %0h expected none", a_out_pc);
      end else check_rec("a_out", act[0], exp_q0.pop_front());
    end
    if (rst_n && b_out_valid && out_ready[1] && !flush[1]) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_output: got pc %0h expected none", b_out_pc);
      end else check_rec("b_out", act[1], exp_q1.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int d, input logic [31:0] inst, input logic [63:0] pc, input rec_t e);
    bit ok;
    ok = 1'b0;
    in_valid[d] = 1'b1;
    in_inst[d]  = inst;
    in_pc[d]    = pc;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_rdy[d]) begin
        ok = 1'b1;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut %0d pc %0h not accepted within 20 cycles", d, pc);
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- vector table ----------------
  vec_t vecs[$];

  task automatic add(input int d, input logic [31:0] inst, input logic [4:0] opc, input logic [5:0] ty,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm, input logic ill);
    vec_t v;
    logic [63:0] pc;
    pc = (d == 0) ? 64'h0000_0000_0000_0100 + 64'(4 * vecs.size())
                  : 64'hFFFF_FFFF_0000_0200 + 64'(4 * vecs.size());
    v.dut  = d;
    v.inst = inst;
    v.exp  = mk(pc, opc, ty, rd, rs1, rs2, f3, f7, imm, ill);
    vecs.push_back(v);
  endtask

  localparam logic [31:0] ADDI = 32'hFFF10093;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_inst[d] = '0; in_pc[d] = '0;
      out_ready[d] = 1'b0; flush[d] = 1'b0;
    end

    // XLEN=32, EN_F=0
    add(0, 32'hFFF10093, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0);
    add(0, 32'h123452B7, 5'h0D, T_U, 5, 0, 0, 0, 0, 64'h1234_5000, 0);
    add(0, 32'hFE208EE3, 5'h18, T_B, 0, 1, 2, 0, 0, 64'hFFFF_FFFC, 0);
    add(0, 32'h001000EF, 5'h1B, T_J, 1, 0, 0, 0, 0, 64'h0000_0800, 0);
    add(0, 32'h40520233, 5'h0C, T_R, 4, 4, 5, 0, 7'h20, 64'h0, 0);
    add(0, 32'h00512423, 5'h08, T_S, 0, 2, 5, 2, 0, 64'h0000_0008, 0);
    add(0, 32'h80002083, 5'h00, T_I, 1, 0, 0, 2, 0, 64'hFFFF_F800, 0);
    add(0, 32'h00000073, 5'h1C, T_I, 0, 0, 0, 0, 0, 64'h0, 0);
    add(0, 32'h00000001, 5'h00, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    add(0, 32'hFFF10090, 5'h04, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    add(0, 32'h0000001B, 5'h06, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    add(0, 32'h00000007, 5'h01, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    add(0, 32'h0000001F, 5'h07, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    add(0, 32'h0000000B, 5'h02, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    add(0, 32'hFFFFFFFF, 5'h1F, T_N, 0, 0, 0, 0, 0, 64'h0, 1);
    // XLEN=64, EN_F=1
    add(1, 32'h800002B7, 5'h0D, T_U, 5, 0, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 0);
    add(1, 32'hFFF10093, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add(1, 32'h0000001B, 5'h06, T_I, 0, 0, 0, 0, 0, 64'h0, 0);
    add(1, 32'hFFF1009B, 5'h06, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add(1, 32'h0000003B, 5'h0E, T_R, 0, 0, 0, 0, 0, 64'h0, 0);
    add(1, 32'h00000007, 5'h01, T_I, 0, 0, 0, 0, 0, 64'h0, 0);
    add(1, 32'h00000027, 5'h09, T_S, 0, 0, 0, 0, 0, 64'h0, 0);
    add(1, 32'h00000053, 5'h14, T_R, 0, 0, 0, 0, 0, 64'h0, 0);
    add(1, 32'h001000EF, 5'h1B, T_J, 1, 0, 0, 0, 0, 64'h0000_0800, 0);
    add(1, 32'h0000007B, 5'h1E, T_N, 0, 0, 0, 0, 0, 64'h0, 1);

    // ---- reset state ----
    cycles(3);
    @(negedge clk);
    check("a_reset_out_valid", 64'(a_out_valid), 0);
    check("b_reset_out_valid", 64'(b_out_valid), 0);
    check("a_reset_in_ready", 64'(a_in_ready), 0);
    check("b_reset_in_ready", 64'(b_in_ready), 0);
    check_rec("a_reset_outs", act[0], '0);
    check_rec("b_reset_outs", act[1], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("a_in_ready_after_reset", 64'(a_in_ready), 1);
    check("b_in_ready_after_reset", 64'(b_in_ready), 1);
    @(posedge clk); #1;

    // ---- table: back-to-back decode with the consumer always ready ----
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    foreach (vecs[i]) send(vecs[i].dut, vecs[i].inst, vecs[i].exp.pc, vecs[i].exp);
    cycles(4);
    @(negedge clk);
    check("a_idle_out_valid", 64'(a_out_valid), 0);
    check("b_idle_out_valid", 64'(b_out_valid), 0);
    @(posedge clk); #1;

    // ---- back-pressure on the skid instance ----
    out_ready[0] = 1'b0;
    send(0, ADDI, 64'h0, mk(64'h0, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    send(0, ADDI, 64'h4, mk(64'h4, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    in_valid[0] = 1'b1; in_inst[0] = ADDI; in_pc[0] = 64'h8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_stall_in_ready", 64'(a_in_ready), 0);
      check_rec("a_stall_hold", act[0], mk(64'h0, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    send(0, ADDI, 64'h8, mk(64'h8, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    cycles(4);

    // ---- back-pressure on the single-register instance ----
    out_ready[1] = 1'b0;
    send(1, ADDI, 64'h0, mk(64'h0, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    in_valid[1] = 1'b1; in_inst[1] = ADDI; in_pc[1] = 64'h4;
    @(negedge clk);
    check("b_stall_in_ready", 64'(b_in_ready), 0);
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    send(1, ADDI, 64'h4, mk(64'h4, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    send(1, ADDI, 64'h8, mk(64'h8, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    cycles(4);

    // ---- flush while holding two instructions ----
    out_ready[0] = 1'b0;
    send(0, ADDI, 64'h10, mk(64'h10, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    send(0, ADDI, 64'h14, mk(64'h14, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    flush[0] = 1'b1;
    in_valid[0] = 1'b1; in_inst[0] = ADDI; in_pc[0] = 64'h18;
    @(negedge clk);
    check("a_flush_in_ready", 64'(a_in_ready), 0);
    @(posedge clk); #1;
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    exp_q0.delete();
    @(negedge clk);
    check("a_post_flush_out_valid", 64'(a_out_valid), 0);
    check("a_post_flush_in_ready", 64'(a_in_ready), 1);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(0, 32'h123452B7, 64'h18, mk(64'h18, 5'h0D, T_U, 5, 0, 0, 0, 0, 64'h1234_5000, 0));
    cycles(3);

    // ---- reset while holding two instructions ----
    out_ready[0] = 1'b0;
    send(0, ADDI, 64'h20, mk(64'h20, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    send(0, ADDI, 64'h24, mk(64'h24, 5'h04, T_I, 1, 2, 0, 0, 0, 64'hFFFF_FFFF, 0));
    rst_n = 1'b0;
    @(negedge clk);
    check("a_in_ready_in_reset", 64'(a_in_ready), 0);
    @(posedge clk); #1;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    check("a_stall_reset_out_valid", 64'(a_out_valid), 0);
    check_rec("a_stall_reset_outs", act[0], '0);
    check_rec("b_stall_reset_outs", act[1], '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("a_in_ready_after_stall_reset", 64'(a_in_ready), 1);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(0, 32'hFE208EE3, 64'h28, mk(64'h28, 5'h18, T_B, 0, 1, 2, 0, 0, 64'hFFFF_FFFC, 0));
    cycles(4);

    // ---- everything pushed must have come out ----
    check("a_queue_drained", 64'(exp_q0.size()), 0);
    check("b_queue_drained", 64'(exp_q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
